// File: rtl/mem_stage_mc.sv
// Multi-cycle data-memory stage: word-organised array with configurable access latency,
// stall back-pressure, misaligned/conflict rejection and a sticky drain-then-halt state.
//
// state | meaning
// IDLE  | ready for a request; LATENCY=1 accesses complete here
// BUSY  | multi-cycle access in flight, using only latched op/index/wdata
module mem_stage_mc #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic              halted
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt;
  logic                    op_wr_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    halt_q;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic [DEPTH_LOG2-1:0]   idx;
  logic                    req, bad, accept, last;
  logic                    we;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic [DATA_W-1:0]       w_data;
  logic                    set_halt;

  assign idx    = addr[DEPTH_LOG2:1];
  assign req    = (mem_read | mem_write) & ~halted & (state == IDLE);
  assign bad    = req & (addr[0] | (mem_read & mem_write));
  assign accept = req & ~bad;
  assign last   = (state == BUSY) && (cnt == CNT_LAST);

  // Upper address bits are deliberately ignored so addresses wrap modulo the depth.
  generate
    if (DEPTH_LOG2 + 1 < ADDR_W) begin : g_upper
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[ADDR_W-1:DEPTH_LOG2+1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && LATENCY > 1) state_nx = BUSY;
      BUSY: if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdata  = '0;
    stall  = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    we     = 1'b0;
    w_idx  = idx;
    w_data = wdata;
    case (state)
      IDLE: begin
        err = bad;
        if (accept) begin
          if (LATENCY == 1) begin
            done  = 1'b1;
            rdata = mem_read ? mem[idx] : '0;
            we    = mem_write;
          end else begin
            stall = 1'b1;
          end
        end
      end
      BUSY: begin
        stall  = ~last;
        done   = last;
        rdata  = (last && !op_wr_q) ? mem[idx_q] : '0;
        we     = last & op_wr_q;
        w_idx  = idx_q;
        w_data = wdata_q;
      end
      default: ;
    endcase
  end

  // A halt seen alongside or during an access is held until that access completes.
  assign set_halt = ((state == IDLE) && halt && !accept) || (done && (halt || halt_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      halt_q  <= 1'b0;
      halted  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (accept && LATENCY > 1) begin
          cnt     <= CNT_W'(1);
          op_wr_q <= mem_write;
          idx_q   <= idx;
          wdata_q <= wdata;
          halt_q  <= halt;
        end
      end else begin
        if (last) begin
          cnt    <= '0;
          halt_q <= 1'b0;
        end else begin
          cnt    <= cnt + CNT_W'(1);
          halt_q <= halt_q | halt;
        end
      end
      if (set_halt) halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[w_idx] <= w_data;
    end
  end

endmodule
